// File: rtl/hyper_pkg.sv
// Shared types and helpers for the HyperBus page-boundary splitter.
//   page_bound_e : encoding of the HyperRAM page size (1xx = no boundary)
//   pbs_state_e  : splitter FSM states
//   page_size()  : page size in bytes for a page_bound code
package hyper_pkg;

  typedef enum logic [2:0] {
    PB_128  = 3'b000,
    PB_256  = 3'b001,
    PB_512  = 3'b010,
    PB_1K   = 3'b011,
    PB_NONE = 3'b100
  } page_bound_e;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } pbs_state_e;

  // Only the two LSBs select the size; bit 2 (no boundary) is handled by callers.
  function automatic logic [10:0] page_size(input page_bound_e pb);
    logic [2:0] pb_bits;
    pb_bits = pb;
    return 11'd128 << pb_bits[1:0];
  endfunction

endpackage

// File: rtl/hyper_page_bound_splitter_if.sv
// Handshake/bus bundle of the page-boundary splitter.
//   slave  : splitter view (accepts src_* transfers, issues dst_* chunks)
//   master : environment view (drives transfers, consumes chunks)
interface hyper_page_bound_splitter_if #(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int ID_WIDTH       = 1,
  parameter int TRANS_SIZE     = 16
);
  logic                      src_valid_i;
  logic                      src_ready_o;
  logic [31:0]               hyper_addr_i;
  logic [L2_AWIDTH_NOAL-1:0] l2_addr_i;
  logic [TRANS_SIZE-1:0]     size_i;
  logic [2:0]                page_bound_i;
  logic                      rw_hyper_i;
  logic                      addr_space_i;
  logic [ID_WIDTH:0]         trans_id_i;

  logic                      dst_valid_o;
  logic                      dst_ready_i;
  logic [31:0]               hyper_addr_o;
  logic [L2_AWIDTH_NOAL-1:0] l2_addr_o;
  logic [TRANS_SIZE-1:0]     size_o;
  logic                      last_o;
  logic                      rw_hyper_o;
  logic                      addr_space_o;
  logic [ID_WIDTH:0]         trans_id_o;

  modport slave (
    input  src_valid_i, hyper_addr_i, l2_addr_i, size_i, page_bound_i,
           rw_hyper_i, addr_space_i, trans_id_i, dst_ready_i,
    output src_ready_o, dst_valid_o, hyper_addr_o, l2_addr_o, size_o,
           last_o, rw_hyper_o, addr_space_o, trans_id_o
  );

  modport master (
    output src_valid_i, hyper_addr_i, l2_addr_i, size_i, page_bound_i,
           rw_hyper_i, addr_space_i, trans_id_i, dst_ready_i,
    input  src_ready_o, dst_valid_o, hyper_addr_o, l2_addr_o, size_o,
           last_o, rw_hyper_o, addr_space_o, trans_id_o
  );
endinterface

// File: rtl/hyper_page_chunk_calc.sv
// Combinational chunk sizing: bytes that can be issued from the current
// address without crossing the selected HyperRAM page.
//   addr_i       : low 11 bits of the current external address (pages <= 1 KiB)
//   rem_i        : bytes still to issue
//   page_bound_i : page code (bit 2 set = no boundary)
//   addr_space_i : 1 = register space (never split)
//   size_o       : bytes in this chunk
//   last_o       : this chunk finishes the transfer
module hyper_page_chunk_calc
  import hyper_pkg::*;
#(
  parameter int TRANS_SIZE = 16
) (
  input  logic [10:0]           addr_i,
  input  logic [TRANS_SIZE-1:0] rem_i,
  input  logic [2:0]            page_bound_i,
  input  logic                  addr_space_i,
  output logic [TRANS_SIZE-1:0] size_o,
  output logic                  last_o
);
  logic [10:0]           psize;
  logic [10:0]           offset;
  logic [10:0]           room;
  logic [TRANS_SIZE-1:0] room_ext;
  logic                  bypass;

  always_comb begin
    psize    = page_size(page_bound_e'(page_bound_i));
    offset   = addr_i & (psize - 11'd1);
    // room is 1..psize, so it always fits in 11 bits
    room     = psize - offset;
    room_ext = TRANS_SIZE'(room);
    bypass   = page_bound_i[2] | addr_space_i | (rem_i == '0);
    size_o   = (bypass || (rem_i <= room_ext)) ? rem_i : room_ext;
    last_o   = (size_o == rem_i);
  end
endmodule

// File: rtl/hyper_page_bound_splitter.sv
// Re-issues each 1D HyperBus transfer as chunks that never cross the
// selected HyperRAM page boundary.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus (slave)  : src_* transfer in (valid/ready), dst_* chunk out
//                  (valid/ready) with address, L2 address, size, last
//                  and registered rw/addr_space/id copies
module hyper_page_bound_splitter
  import hyper_pkg::*;
#(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int ID_WIDTH       = 1,
  parameter int TRANS_SIZE     = 16
) (
  input logic                         clk_i,
  input logic                         rst_i,
  hyper_page_bound_splitter_if.slave  bus
);
  // MSB-only id marks "no transaction in flight"
  localparam logic [ID_WIDTH:0] ID_IDLE = {1'b1, {ID_WIDTH{1'b0}}};

  pbs_state_e                state_q, state_d;
  logic [31:0]               hyper_addr_q, hyper_addr_d;
  logic [L2_AWIDTH_NOAL-1:0] l2_addr_q, l2_addr_d;
  logic [TRANS_SIZE-1:0]     rem_q, rem_d;
  logic [2:0]                page_bound_q, page_bound_d;
  logic                      rw_hyper_q, rw_hyper_d;
  logic                      addr_space_q, addr_space_d;
  logic [ID_WIDTH:0]         trans_id_q, trans_id_d;

  logic [TRANS_SIZE-1:0]     chunk_size;
  logic                      chunk_last;

  hyper_page_chunk_calc #(
    .TRANS_SIZE (TRANS_SIZE)
  ) u_chunk_calc (
    .addr_i       (hyper_addr_q[10:0]),
    .rem_i        (rem_q),
    .page_bound_i (page_bound_q),
    .addr_space_i (addr_space_q),
    .size_o       (chunk_size),
    .last_o       (chunk_last)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      hyper_addr_q <= '0;
      l2_addr_q    <= '0;
      rem_q        <= '0;
      page_bound_q <= '0;
      rw_hyper_q   <= 1'b0;
      addr_space_q <= 1'b0;
      trans_id_q   <= ID_IDLE;
    end else begin
      state_q      <= state_d;
      hyper_addr_q <= hyper_addr_d;
      l2_addr_q    <= l2_addr_d;
      rem_q        <= rem_d;
      page_bound_q <= page_bound_d;
      rw_hyper_q   <= rw_hyper_d;
      addr_space_q <= addr_space_d;
      trans_id_q   <= trans_id_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    hyper_addr_d = hyper_addr_q;
    l2_addr_d    = l2_addr_q;
    rem_d        = rem_q;
    page_bound_d = page_bound_q;
    rw_hyper_d   = rw_hyper_q;
    addr_space_d = addr_space_q;
    trans_id_d   = trans_id_q;
    case (state_q)
      IDLE: begin
        if (bus.src_valid_i) begin
          hyper_addr_d = bus.hyper_addr_i;
          l2_addr_d    = bus.l2_addr_i;
          rem_d        = bus.size_i;
          page_bound_d = bus.page_bound_i;
          rw_hyper_d   = bus.rw_hyper_i;
          addr_space_d = bus.addr_space_i;
          trans_id_d   = bus.trans_id_i;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.dst_ready_i) begin
          // Both addresses wrap naturally at their register widths
          hyper_addr_d = hyper_addr_q + 32'(chunk_size);
          l2_addr_d    = l2_addr_q + L2_AWIDTH_NOAL'(chunk_size);
          rem_d        = rem_q - chunk_size;
          if (chunk_last) begin
            state_d    = IDLE;
            trans_id_d = ID_IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs come from the state register only
  assign bus.src_ready_o  = (state_q == IDLE);
  assign bus.dst_valid_o  = (state_q == ISSUE);
  assign bus.hyper_addr_o = hyper_addr_q;
  assign bus.l2_addr_o    = l2_addr_q;
  assign bus.size_o       = chunk_size;
  // With rem=0 in IDLE the calculator reports last; only meaningful while issuing
  assign bus.last_o       = (state_q == ISSUE) & chunk_last;
  assign bus.rw_hyper_o   = rw_hyper_q;
  assign bus.addr_space_o = addr_space_q;
  assign bus.trans_id_o   = trans_id_q;
endmodule

// File: tb/tb_hyper_page_bound_splitter.sv
module tb_hyper_page_bound_splitter;
  import hyper_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_vec  = 0;
  int   n_fail = 0;

  always #5 clk_i = ~clk_i;

  hyper_page_bound_splitter_if #(.L2_AWIDTH_NOAL(12), .ID_WIDTH(1), .TRANS_SIZE(16)) bus ();

  hyper_page_bound_splitter #(.L2_AWIDTH_NOAL(12), .ID_WIDTH(1), .TRANS_SIZE(16)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input logic [31:0] addr, input logic [11:0] l2, input logic [15:0] size,
                         input logic [2:0] pb, input logic rw, input logic as_, input logic [1:0] id);
    bus.hyper_addr_i = addr;
    bus.l2_addr_i    = l2;
    bus.size_i       = size;
    bus.page_bound_i = pb;
    bus.rw_hyper_i   = rw;
    bus.addr_space_i = as_;
    bus.trans_id_i   = id;
    bus.src_valid_i  = 1'b1;
  endtask

  task automatic send(input logic [31:0] addr, input logic [11:0] l2, input logic [15:0] size,
                      input logic [2:0] pb, input logic rw, input logic as_, input logic [1:0] id);
    set_src(addr, l2, size, pb, rw, as_, id);
    chk("accept_ready", 64'(bus.src_ready_o), 64'd1);
    step();
    bus.src_valid_i = 1'b0;
  endtask

  // Checks the presented chunk, then lets one handshake happen
  task automatic expect_chunk(input string tag, input logic [31:0] addr, input logic [11:0] l2,
                              input logic [15:0] size, input logic last);
    chk({tag, "_valid"}, 64'(bus.dst_valid_o), 64'd1);
    chk({tag, "_addr"},  64'(bus.hyper_addr_o), 64'(addr));
    chk({tag, "_l2"},    64'(bus.l2_addr_o), 64'(l2));
    chk({tag, "_size"},  64'(bus.size_o), 64'(size));
    chk({tag, "_last"},  64'(bus.last_o), 64'(last));
    chk({tag, "_srdy"},  64'(bus.src_ready_o), 64'd0);
    $display("chunk %s: addr=0x%08h l2=0x%03h size=%0d last=%0d", tag,
             bus.hyper_addr_o, bus.l2_addr_o, bus.size_o, bus.last_o);
    step();
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, "_valid"}, 64'(bus.dst_valid_o), 64'd0);
    chk({tag, "_srdy"},  64'(bus.src_ready_o), 64'd1);
    chk({tag, "_id"},    64'(bus.trans_id_o), 64'd2);
  endtask

  initial begin
    bus.src_valid_i  = 1'b0;
    bus.hyper_addr_i = '0;
    bus.l2_addr_i    = '0;
    bus.size_i       = '0;
    bus.page_bound_i = '0;
    bus.rw_hyper_i   = 1'b0;
    bus.addr_space_i = 1'b0;
    bus.trans_id_i   = '0;
    bus.dst_ready_i  = 1'b1;
    step();
    step();
    rst_i = 1'b0;

    // Reset state
    chk("rst_srdy", 64'(bus.src_ready_o), 64'd1);
    chk("rst_valid", 64'(bus.dst_valid_o), 64'd0);
    chk("rst_addr", 64'(bus.hyper_addr_o), 64'd0);
    chk("rst_l2", 64'(bus.l2_addr_o), 64'd0);
    chk("rst_size", 64'(bus.size_o), 64'd0);
    chk("rst_last", 64'(bus.last_o), 64'd0);
    chk("rst_rw", 64'(bus.rw_hyper_o), 64'd0);
    chk("rst_as", 64'(bus.addr_space_o), 64'd0);
    chk("rst_id", 64'(bus.trans_id_o), 64'd2);

    // Aligned, 300 bytes over 128B pages
    send(32'h0, 12'h010, 16'd300, PB_128, 1'b1, 1'b0, 2'b01);
    chk("al_id", 64'(bus.trans_id_o), 64'd1);
    chk("al_rw", 64'(bus.rw_hyper_o), 64'd1);
    expect_chunk("al0", 32'h000, 12'h010, 16'd128, 1'b0);
    expect_chunk("al1", 32'h080, 12'h090, 16'd128, 1'b0);
    expect_chunk("al2", 32'h100, 12'h110, 16'd44, 1'b1);
    expect_idle("al_end");

    // Unaligned start, L2 address wraps at 12 bits
    send(32'h0F0, 12'hFF0, 16'd64, PB_256, 1'b0, 1'b0, 2'b00);
    expect_chunk("un0", 32'h0F0, 12'hFF0, 16'd16, 1'b0);
    expect_chunk("un1", 32'h100, 12'h000, 16'd48, 1'b1);
    expect_idle("un_end");

    // No boundary
    send(32'h1234, 12'h000, 16'd4000, PB_NONE, 1'b0, 1'b0, 2'b01);
    expect_chunk("nb", 32'h1234, 12'h000, 16'd4000, 1'b1);
    expect_idle("nb_end");

    // Register space straddling a 128B boundary is not split
    send(32'h7F, 12'h020, 16'd2, PB_128, 1'b1, 1'b1, 2'b00);
    chk("rs_as", 64'(bus.addr_space_o), 64'd1);
    expect_chunk("rs", 32'h7F, 12'h020, 16'd2, 1'b1);
    expect_idle("rs_end");

    // Zero-size transfer
    send(32'h40, 12'h030, 16'd0, PB_128, 1'b0, 1'b0, 2'b01);
    expect_chunk("z", 32'h40, 12'h030, 16'd0, 1'b1);
    expect_idle("z_end");

    // Backpressure on the second of three chunks
    send(32'h3C0, 12'h100, 16'd200, PB_128, 1'b0, 1'b0, 2'b00);
    expect_chunk("bp0", 32'h3C0, 12'h100, 16'd64, 1'b0);
    bus.dst_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", 64'(bus.dst_valid_o), 64'd1);
      chk("bp_hold_addr", 64'(bus.hyper_addr_o), 64'h400);
      chk("bp_hold_size", 64'(bus.size_o), 64'd128);
      chk("bp_hold_srdy", 64'(bus.src_ready_o), 64'd0);
      $display("hold %0d: addr=0x%08h size=%0d", i, bus.hyper_addr_o, bus.size_o);
      step();
    end
    bus.dst_ready_i = 1'b1;
    expect_chunk("bp1", 32'h400, 12'h140, 16'd128, 1'b0);
    expect_chunk("bp2", 32'h480, 12'h1C0, 16'd8, 1'b1);
    expect_idle("bp_end");

    // Back-to-back with src_valid held high
    set_src(32'h80, 12'h000, 16'd256, PB_256, 1'b0, 1'b0, 2'b01);
    chk("bb_a_ready", 64'(bus.src_ready_o), 64'd1);
    step();
    set_src(32'h500, 12'h200, 16'd10, PB_1K, 1'b1, 1'b0, 2'b00);
    chk("bb_a_id", 64'(bus.trans_id_o), 64'd1);
    expect_chunk("bba0", 32'h080, 12'h000, 16'd128, 1'b0);
    expect_chunk("bba1", 32'h100, 12'h080, 16'd128, 1'b1);
    chk("bb_gap_srdy", 64'(bus.src_ready_o), 64'd1);
    chk("bb_gap_valid", 64'(bus.dst_valid_o), 64'd0);
    step();
    bus.src_valid_i = 1'b0;
    chk("bb_b_id", 64'(bus.trans_id_o), 64'd0);
    chk("bb_b_rw", 64'(bus.rw_hyper_o), 64'd1);
    expect_chunk("bbb", 32'h500, 12'h200, 16'd10, 1'b1);
    expect_idle("bb_end");

    // Reset during chunk 2 of 3
    send(32'h0, 12'h000, 16'd300, PB_128, 1'b0, 1'b0, 2'b01);
    expect_chunk("rr0", 32'h000, 12'h000, 16'd128, 1'b0);
    chk("rr1_addr", 64'(bus.hyper_addr_o), 64'h080);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("rr_valid", 64'(bus.dst_valid_o), 64'd0);
    chk("rr_srdy", 64'(bus.src_ready_o), 64'd1);
    chk("rr_id", 64'(bus.trans_id_o), 64'd2);
    chk("rr_last", 64'(bus.last_o), 64'd0);
    step();
    chk("rr_after_valid", 64'(bus.dst_valid_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
